// File: rtl/uart_sample_streamer.sv
// Sample FIFO and framer feeding a one-word trigger/busy transmitter.
// Inserts SYNC_WORD before every FRAME_LEN samples and escapes samples equal to it.
module uart_sample_streamer #(
  parameter int          DEPTH     = 16,
  parameter int          FRAME_LEN = 64,
  parameter logic [15:0] SYNC_WORD = 16'hA5A5
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       enable_in,
  input  logic [15:0]                sample_in,
  input  logic                       sample_valid_in,
  output logic [15:0]                tx_data_out,
  output logic                       tx_trigger_out,
  input  logic                       tx_busy_in,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count_out,
  output logic                       overflow_out,
  output logic [7:0]                 drop_count_out,
  input  logic                       clear_overflow_in,
  output logic [1:0]                 state_dbg_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCEPT = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          hdr_q, hdr_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   data_q, data_d;
  logic          trig_q, trig_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  logic        push, drop, can_issue, issue_hdr, pop;
  logic [15:0] head_word, esc_word;

  // Drops are decided on the registered count, so a same-cycle pop never frees a slot.
  assign push      = sample_valid_in && (count_q != FULL);
  assign drop      = sample_valid_in && (count_q == FULL);
  assign can_issue = (state_q == IDLE) && enable_in && (count_q != '0);
  assign issue_hdr = can_issue && (frame_q == '0) && !hdr_q;
  assign pop       = can_issue && !issue_hdr;
  assign head_word = mem_q[rd_ptr_q];
  assign esc_word  = (head_word == SYNC_WORD) ? (SYNC_WORD ^ 16'h0001) : head_word;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    trig_d  = 1'b0;
    frame_d = frame_q;
    hdr_d   = hdr_q;
    case (state_q)
      IDLE: begin
        if (!enable_in) begin
          frame_d = '0;
          hdr_d   = 1'b0;
        end else if (issue_hdr) begin
          data_d  = SYNC_WORD;
          hdr_d   = 1'b1;
          trig_d  = 1'b1;
          state_d = ACCEPT;
        end else if (pop) begin
          data_d  = esc_word;
          trig_d  = 1'b1;
          state_d = ACCEPT;
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            hdr_d   = 1'b0;
          end else begin
            frame_d = frame_q + FW'(1);
          end
        end
      end
      // The transmitter's busy is registered, so it is not yet valid here.
      ACCEPT:  state_d = DRAIN;
      DRAIN:   if (!tx_busy_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clear_overflow_in) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end else if (drop) begin
      ovf_d  = 1'b1;
      drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      frame_q  <= '0;
      hdr_q    <= 1'b0;
      state_q  <= IDLE;
      data_q   <= '0;
      trig_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      frame_q <= frame_d;
      hdr_q   <= hdr_d;
      state_q <= state_d;
      data_q  <= data_d;
      trig_q  <= trig_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign tx_data_out    = data_q;
  assign tx_trigger_out = trig_q;
  assign fifo_count_out = count_q;
  assign overflow_out   = ovf_q;
  assign drop_count_out = drop_q;
  assign state_dbg_out  = state_q;

endmodule
